// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: op field width and next-PC op codes.
package pc_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] PC_INC    = 3'd0;
   localparam logic [OP_W-1:0] PC_JUMP   = 3'd1;
   localparam logic [OP_W-1:0] PC_BRANCH = 3'd2;
   localparam logic [OP_W-1:0] PC_CALL   = 3'd3;
   localparam logic [OP_W-1:0] PC_RET    = 3'd4;
   localparam logic [OP_W-1:0] PC_HOLD   = 3'd5;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push writes above the top pointer, pop retreats it.
// A push while full overwrites the oldest entry and leaves the count saturated.
module pc_ras #(
   parameter int WIDTH     = 16,
   parameter int RAS_DEPTH = 8,
   localparam int PTR_W    = $clog2(RAS_DEPTH),
   localparam int CNT_W    = $clog2(RAS_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);
   import pc_pkg::*;

   logic [WIDTH-1:0] mem_q [RAS_DEPTH];
   logic [WIDTH-1:0] mem_d [RAS_DEPTH];
   logic [PTR_W-1:0] tp_q, tp_d;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count_q, count_d;

   assign full     = (count_q == CNT_W'(RAS_DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign top_data = mem_q[tp_q];
   assign wr_ptr   = tp_q + PTR_W'(1);

   // Pointer wrap relies on RAS_DEPTH being a power of two.
   always_comb begin
      mem_d   = mem_q;
      tp_d    = tp_q;
      count_d = count_q;
      if (push) begin
         mem_d[wr_ptr] = push_data;
         tp_d          = wr_ptr;
         if (!full) count_d = count_q + CNT_W'(1);
      end else if (pop && !empty) begin
         tp_d    = tp_q - PTR_W'(1);
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tp_q    <= '0;
         count_q <= '0;
      end else begin
         tp_q    <= tp_d;
         count_q <= count_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC mux, PC register, sticky RAS fault flags,
// with call/return addresses held in a hardware return-address stack.
module pc_unit #(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               RAS_DEPTH    = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               stall,
   input  logic [2:0]                         op,
   input  logic [WIDTH-1:0]                   target,
   input  logic [WIDTH-1:0]                   offset,
   input  logic                               clear_fault,
   output logic [WIDTH-1:0]                   pc,
   output logic [WIDTH-1:0]                   pc_plus_one,
   output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
   output logic                               ras_empty,
   output logic                               ras_full,
   output logic                               ras_overflow,
   output logic                               ras_underflow
);
   import pc_pkg::*;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             push, pop;
   logic             ovf_set, udf_set;
   logic [WIDTH-1:0] top_data;

   assign pc            = pc_q;
   assign pc_plus_one   = pc_q + WIDTH'(1);
   assign ras_overflow  = ovf_q;
   assign ras_underflow = udf_q;

   pc_ras #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data (pc_plus_one),
      .top_data  (top_data),
      .count     (ras_count),
      .full      (ras_full),
      .empty     (ras_empty)
   );

   // Stall suppresses the op entirely, including fault detection.
   always_comb begin
      pc_d    = pc_q;
      push    = 1'b0;
      pop     = 1'b0;
      ovf_set = 1'b0;
      udf_set = 1'b0;
      if (!stall) begin
         case (op)
            PC_INC:    pc_d = pc_plus_one;
            PC_JUMP:   pc_d = target;
            PC_BRANCH: pc_d = pc_q + offset;
            PC_CALL: begin
               push    = 1'b1;
               ovf_set = ras_full;
               pc_d    = target;
            end
            PC_RET: begin
               if (ras_empty) begin
                  udf_set = 1'b1;
               end else begin
                  pop  = 1'b1;
                  pc_d = top_data;
               end
            end
            default:   pc_d = pc_q;
         endcase
      end
   end

   // A fault in the same cycle as clear_fault leaves the flag set.
   always_comb begin
      ovf_d = clear_fault ? 1'b0 : ovf_q;
      udf_d = clear_fault ? 1'b0 : udf_q;
      if (ovf_set) ovf_d = 1'b1;
      if (udf_set) udf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q  <= RESET_VECTOR;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random ops, checked against a queue-based model.
module tb_pc_unit;

   localparam int          WIDTH = 16;
   localparam logic [15:0] RV    = 16'h0100;
   localparam int          DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst, stall, clear_fault;
   logic [2:0]  op;
   logic [15:0] target, offset;
   logic [15:0] pc, pc_plus_one;
   logic [3:0]  ras_count;
   logic        ras_empty, ras_full, ras_overflow, ras_underflow;

   int checks = 0;
   int errors = 0;

   logic [15:0] m_pc;
   logic [15:0] m_stack[$];
   logic        m_ovf, m_udf;

   pc_unit #(
      .WIDTH        (WIDTH),
      .RESET_VECTOR (RV),
      .RAS_DEPTH    (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .op            (op),
      .target        (target),
      .offset        (offset),
      .clear_fault   (clear_fault),
      .pc            (pc),
      .pc_plus_one   (pc_plus_one),
      .ras_count     (ras_count),
      .ras_empty     (ras_empty),
      .ras_full      (ras_full),
      .ras_overflow  (ras_overflow),
      .ras_underflow (ras_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_update(input logic [2:0] o, input logic [15:0] t, input logic [15:0] off,
                               input logic s, input logic cf, input logic r);
      logic [15:0] lnk;
      if (!r) begin
         m_pc = RV;
         m_stack.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         return;
      end
      if (cf) begin
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end
      if (s) return;
      case (o)
         3'd0: m_pc = m_pc + 16'd1;
         3'd1: m_pc = t;
         3'd2: m_pc = m_pc + off;
         3'd3: begin
            lnk = m_pc + 16'd1;
            if (m_stack.size() == DEPTH) begin
               void'(m_stack.pop_front());
               m_ovf = 1'b1;
            end
            m_stack.push_back(lnk);
            m_pc = t;
         end
         3'd4: begin
            if (m_stack.size() == 0) m_udf = 1'b1;
            else m_pc = m_stack.pop_back();
         end
         default: ;
      endcase
   endtask

   task automatic step(input logic [2:0] o, input logic [15:0] t, input logic [15:0] off,
                       input logic s, input logic cf, input logic r);
      logic [15:0] cnt;
      op = o; target = t; offset = off; stall = s; clear_fault = cf; rst = r;
      @(posedge clk);
      model_update(o, t, off, s, cf, r);
      #1;
      cnt = 16'(m_stack.size());
      chk("pc", pc, m_pc);
      chk("pc_plus_one", pc_plus_one, m_pc + 16'd1);
      chk("ras_count", {12'd0, ras_count}, cnt);
      chk("ras_empty", {15'd0, ras_empty}, {15'd0, cnt == 16'd0});
      chk("ras_full", {15'd0, ras_full}, {15'd0, cnt == 16'(DEPTH)});
      chk("ras_overflow", {15'd0, ras_overflow}, {15'd0, m_ovf});
      chk("ras_underflow", {15'd0, ras_underflow}, {15'd0, m_udf});
   endtask

   task automatic go(input logic [2:0] o, input logic [15:0] t);
      step(o, t, 16'h0000, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; clear_fault = 1'b0;
      op = 3'd0; target = '0; offset = '0;
      m_pc = '0; m_ovf = 1'b0; m_udf = 1'b0;

      // reset and increment
      step(3'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      step(3'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("reset_pc", pc, 16'h0100);
      chk("reset_ppo", pc_plus_one, 16'h0101);
      chk("reset_empty", {15'd0, ras_empty}, 16'd1);
      go(3'd0, 16'h0); chk("inc1", pc, 16'h0101);
      go(3'd0, 16'h0); chk("inc2", pc, 16'h0102);
      go(3'd0, 16'h0); chk("inc3", pc, 16'h0103);

      // wrap and branch
      go(3'd1, 16'hFFFF); chk("jump", pc, 16'hFFFF);
      chk("ppo_wrap", pc_plus_one, 16'h0000);
      go(3'd0, 16'h0); chk("inc_wrap", pc, 16'h0000);
      step(3'd2, 16'h0, 16'hFFFE, 1'b0, 1'b0, 1'b1); chk("branch_neg", pc, 16'hFFFE);

      // nested call/return
      go(3'd1, 16'h0010);
      go(3'd3, 16'h0200); chk("call1", pc, 16'h0200); chk("cnt1", {12'd0, ras_count}, 16'd1);
      go(3'd3, 16'h0300); chk("call2", pc, 16'h0300); chk("cnt2", {12'd0, ras_count}, 16'd2);
      go(3'd4, 16'h0);    chk("ret1", pc, 16'h0201);  chk("cnt3", {12'd0, ras_count}, 16'd1);
      go(3'd4, 16'h0);    chk("ret2", pc, 16'h0011);  chk("cnt4", {12'd0, ras_count}, 16'd0);

      // overflow: 9 calls, link values 0x1001..0x1009, first one lost
      go(3'd1, 16'h1000);
      for (int i = 0; i < 9; i++) go(3'd3, 16'h1001 + 16'(i));
      chk("ovf_set", {15'd0, ras_overflow}, 16'd1);
      chk("ovf_full", {15'd0, ras_full}, 16'd1);
      chk("ovf_cnt", {12'd0, ras_count}, 16'd8);
      for (int i = 0; i < 8; i++) begin
         go(3'd4, 16'h0);
         chk("ovf_ret", pc, 16'h1009 - 16'(i));
      end
      chk("ovf_drained", {15'd0, ras_empty}, 16'd1);
      step(3'd5, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
      chk("ovf_clear", {15'd0, ras_overflow}, 16'd0);

      // underflow and stall
      go(3'd1, 16'h0777);
      go(3'd4, 16'h0); chk("udf_pc", pc, 16'h0777);
      chk("udf_set", {15'd0, ras_underflow}, 16'd1);
      step(3'd3, 16'h0400, 16'h0, 1'b1, 1'b0, 1'b1);
      chk("stall_pc", pc, 16'h0777);
      chk("stall_cnt", {12'd0, ras_count}, 16'd0);
      step(3'd4, 16'h0, 16'h0, 1'b1, 1'b1, 1'b1);
      chk("stall_clear", {15'd0, ras_underflow}, 16'd0);
      step(3'd4, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
      chk("set_wins", {15'd0, ras_underflow}, 16'd1);

      // back-to-back call then ret
      go(3'd3, 16'h0500); go(3'd4, 16'h0); chk("b2b_ret", pc, 16'h0778);

      // reset mid-operation
      for (int i = 0; i < 3; i++) go(3'd3, 16'h2000 + 16'(i));
      step(3'd3, 16'h3000, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("mid_rst_pc", pc, 16'h0100);
      chk("mid_rst_cnt", {12'd0, ras_count}, 16'd0);
      go(3'd4, 16'h0); chk("mid_rst_udf", {15'd0, ras_underflow}, 16'd1);

      // random ops against the model
      for (int i = 0; i < 400; i++) begin
         logic [2:0] o;
         o = ($urandom_range(0, 3) == 0) ? 3'd3 : 3'($urandom_range(0, 7));
         step(o, 16'($urandom), 16'($urandom),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 63) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
